// File: rtl/shared_resource_mc_pkg.sv
// rtl/shared_resource_mc_pkg.sv - shared types, default widths and constant helpers
package shared_resource_mc_pkg;

  localparam int SR_ADDRESS_WIDTH = 16;
  localparam int SR_DATA_WIDTH    = 32;
  localparam int SR_ID_WIDTH      = 4;

  typedef enum logic [1:0] {
    SR_IDLE = 2'd0,
    SR_WAIT = 2'd1,
    SR_RESP = 2'd2
  } sr_state_e;

  function automatic int sr_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_resource_mc_rr_arbiter.sv
// rtl/shared_resource_mc_rr_arbiter.sv - round-robin arbiter, one-hot grant, registered pointer
module shared_resource_mc_rr_arbiter
  import shared_resource_mc_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (sr_clog2(N) > 0) ? sr_clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Scan downward so the last hit written is the first valid channel at or after ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[IDX_W'((int'(ptr) + k) % N)]) begin
        grant     = N'(1) << ((int'(ptr) + k) % N);
        grant_idx = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && (|grant)) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shared_resource_mc.sv
// rtl/shared_resource_mc.sv - multi-channel cached shared resource with round-robin access
module shared_resource_mc
  import shared_resource_mc_pkg::*;
#(
  parameter int                    NUM_CH        = 2,
  parameter int                    ADDRESS_WIDTH = SR_ADDRESS_WIDTH,
  parameter int                    DATA_WIDTH    = SR_DATA_WIDTH,
  parameter int                    ID_WIDTH      = SR_ID_WIDTH,
  parameter int                    CACHE_LINES   = 4,
  parameter int                    HIT_LAT       = 2,
  parameter int                    MISS_LAT      = 8,
  parameter bit                    CT_MODE       = 1'b0,
  parameter bit                    PARTITION     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] DATA_SALT     = DATA_WIDTH'(32'hA5A5_0000),
  parameter int                    CH_W          = (sr_clog2(NUM_CH) > 0) ? sr_clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0]   in_address,
  input  logic [NUM_CH*ID_WIDTH-1:0]        in_id,
  input  logic [NUM_CH-1:0]                 in_valid,
  output logic [NUM_CH-1:0]                 in_ready,
  input  logic                              flush,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic [CH_W-1:0]                   out_channel,
  output logic                              out_valid
);

  localparam int IDX_W  = (sr_clog2(CACHE_LINES) > 0) ? sr_clog2(CACHE_LINES) : 1;
  localparam int PART_W = sr_clog2(NUM_CH);
  localparam int CNT_W  = sr_clog2(MISS_LAT + 1);
  localparam logic [IDX_W-1:0] LOW_MASK = IDX_W'((1 << (IDX_W - PART_W)) - 1);

  sr_state_e state, state_nxt;

  logic [NUM_CH-1:0]        grant;
  logic [CH_W-1:0]          grant_idx;
  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [ID_WIDTH-1:0]      sel_id;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_hit;
  logic [CNT_W-1:0]         sel_lat;

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         lat_q;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [ID_WIDTH-1:0]      req_id;
  logic [CH_W-1:0]          req_channel;
  logic [IDX_W-1:0]         req_idx;
  logic                     req_miss;
  logic                     flush_pend;

  logic [CACHE_LINES-1:0]   line_valid;
  logic [ADDRESS_WIDTH-1:0] line_tag [CACHE_LINES];

  shared_resource_mc_rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept      = (state == SR_IDLE) && (|grant);
  assign in_ready    = (state == SR_IDLE) ? grant : '0;
  assign sel_address = in_address[int'(grant_idx) * ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_id      = in_id[int'(grant_idx) * ID_WIDTH +: ID_WIDTH];

  // Partitioned mode gives each channel its own slice of sets so one channel cannot evict another.
  always_comb begin
    if (PARTITION) begin
      sel_idx = (IDX_W'(grant_idx) << (IDX_W - PART_W)) | (IDX_W'(sel_address) & LOW_MASK);
    end else begin
      sel_idx = IDX_W'(sel_address);
    end
  end

  assign sel_hit = line_valid[sel_idx] && (line_tag[sel_idx] == sel_address);
  assign sel_lat = (CT_MODE || !sel_hit) ? CNT_W'(MISS_LAT) : CNT_W'(HIT_LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cnt starts at 1 on accept, so RESP is entered one edge before the response edge.
  always_comb begin
    state_nxt = state;
    case (state)
      SR_IDLE: begin
        if (accept) begin
          state_nxt = (sel_lat == CNT_W'(1)) ? SR_RESP : SR_WAIT;
        end
      end
      SR_WAIT: begin
        if (cnt == lat_q - 1'b1) begin
          state_nxt = SR_RESP;
        end
      end
      SR_RESP: state_nxt = SR_IDLE;
      default: state_nxt = SR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      lat_q       <= '0;
      req_address <= '0;
      req_id      <= '0;
      req_channel <= '0;
      req_idx     <= '0;
      req_miss    <= 1'b0;
      flush_pend  <= 1'b0;
      line_valid  <= '0;
      for (int i = 0; i < CACHE_LINES; i++) begin
        line_tag[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
      out_channel <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        SR_IDLE: begin
          if (flush) begin
            line_valid <= '0;
          end
          if (accept) begin
            cnt         <= CNT_W'(1);
            lat_q       <= sel_lat;
            req_address <= sel_address;
            req_id      <= sel_id;
            req_channel <= grant_idx;
            req_idx     <= sel_idx;
            req_miss    <= !sel_hit;
          end
        end
        SR_WAIT: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        SR_RESP: begin
          out_valid   <= 1'b1;
          out_data    <= DATA_WIDTH'(req_address) ^ DATA_SALT;
          out_id      <= req_id;
          out_channel <= req_channel;
          if (req_miss) begin
            line_tag[req_idx] <= req_address;
          end
          // A flush seen during this request wins over its own fill.
          if (flush || flush_pend) begin
            line_valid <= '0;
            flush_pend <= 1'b0;
          end else if (req_miss) begin
            line_valid[req_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
